// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared ID/EX definitions: packed control-bundle field offsets and the bubble constant.
// The EX forwarding unit and this register bank decode ctrl through these offsets.
package id_ex_hazard_reg_pkg;

   localparam int unsigned CTRL_W_DEF = 12;

   // Control bundle layout, LSB first
   localparam int unsigned WB_WRITE   = 0;
   localparam int unsigned WB_MEM2REG = 1;
   localparam int unsigned MEM_WRITE  = 2;
   localparam int unsigned MEM_READ   = 3;
   localparam int unsigned ALU_SRC    = 4;
   localparam int unsigned ALU_OP_LSB = 5;
   localparam int unsigned ALU_OP_W   = 7;

   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      SEL_CAPTURE = 2'd0,
      SEL_HOLD    = 2'd1,
      SEL_BUBBLE  = 2'd2
   } ex_sel_e;

   function automatic logic idx_hit(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use detector: the ID instruction reads the non-zero
// destination of a load currently in EX.
module load_use_detect
   import id_ex_hazard_reg_pkg::*;
#(
   parameter int unsigned REG_IDX_W = 5
) (
   input  logic                 valid_ex_i,
   input  logic                 mem_to_reg_ex_i,
   input  logic                 write_reg_ex_i,
   input  logic [REG_IDX_W-1:0] write_reg_idx_ex_i,
   input  logic                 valid_id_i,
   input  logic                 uses_rs1_id_i,
   input  logic                 uses_rs2_id_i,
   input  logic [REG_IDX_W-1:0] rs1_id_i,
   input  logic [REG_IDX_W-1:0] rs2_id_i,
   output logic                 load_use_o
);

   logic producer_is_load;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      producer_is_load = valid_ex_i && mem_to_reg_ex_i && write_reg_ex_i &&
                         (write_reg_idx_ex_i != '0);
      rs1_hit          = uses_rs1_id_i && (rs1_id_i == write_reg_idx_ex_i);
      rs2_hit          = uses_rs2_id_i && (rs2_id_i == write_reg_idx_ex_i);
      load_use_o       = producer_is_load && valid_id_i && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// memory-stall freeze and a saturating load-use bubble counter.
module id_ex_hazard_reg
   import id_ex_hazard_reg_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned CTRL_W    = 12,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_ID,
   input  logic [REG_IDX_W-1:0] read_reg_idx_1_ID,
   input  logic [REG_IDX_W-1:0] read_reg_idx_2_ID,
   input  logic                 uses_rs1_ID,
   input  logic                 uses_rs2_ID,
   input  logic [DATA_W-1:0]    read_data_1_ID,
   input  logic [DATA_W-1:0]    read_data_2_ID,
   input  logic [DATA_W-1:0]    imm_ID,
   input  logic [DATA_W-1:0]    pc_ID,
   input  logic [REG_IDX_W-1:0] write_reg_idx_ID,
   input  logic [CTRL_W-1:0]    ctrl_ID,
   input  logic                 flush_EX,
   input  logic                 stall_MEM,
   output logic                 valid_EX,
   output logic [REG_IDX_W-1:0] read_reg_idx_1_EX,
   output logic [REG_IDX_W-1:0] read_reg_idx_2_EX,
   output logic [DATA_W-1:0]    read_data_1_EX,
   output logic [DATA_W-1:0]    read_data_2_EX,
   output logic [DATA_W-1:0]    imm_EX,
   output logic [DATA_W-1:0]    pc_EX,
   output logic [REG_IDX_W-1:0] write_reg_idx_EX,
   output logic [CTRL_W-1:0]    ctrl_EX,
   output logic                 stall_ID,
   output logic [CNT_W-1:0]     load_use_bubbles
);

   logic                 valid_q, valid_d;
   logic [REG_IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [DATA_W-1:0]    d1_q, d1_d, d2_q, d2_d, imm_q, imm_d, pc_q, pc_d;
   logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 load_use;
   ex_sel_e              sel;

   load_use_detect #(
      .REG_IDX_W (REG_IDX_W)
   ) u_load_use_detect (
      .valid_ex_i         (valid_q),
      .mem_to_reg_ex_i    (ctrl_q[WB_MEM2REG]),
      .write_reg_ex_i     (ctrl_q[WB_WRITE]),
      .write_reg_idx_ex_i (rd_q),
      .valid_id_i         (valid_ID),
      .uses_rs1_id_i      (uses_rs1_ID),
      .uses_rs2_id_i      (uses_rs2_ID),
      .rs1_id_i           (read_reg_idx_1_ID),
      .rs2_id_i           (read_reg_idx_2_ID),
      .load_use_o         (load_use)
   );

   // A flushed ID instruction is wrong-path, so it is never held for a hazard
   assign stall_ID = stall_MEM | (load_use & ~flush_EX);

   always_comb begin
      if (stall_MEM)                 sel = SEL_HOLD;
      else if (flush_EX || load_use) sel = SEL_BUBBLE;
      else                           sel = SEL_CAPTURE;
   end

   always_comb begin
      valid_d = valid_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      case (sel)
         SEL_BUBBLE: begin
            valid_d = 1'b0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            d1_d    = '0;
            d2_d    = '0;
            imm_d   = '0;
            pc_d    = '0;
            ctrl_d  = '0;
            if (!flush_EX && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
         end
         SEL_CAPTURE: begin
            valid_d = valid_ID;
            rs1_d   = read_reg_idx_1_ID;
            rs2_d   = read_reg_idx_2_ID;
            rd_d    = write_reg_idx_ID;
            d1_d    = read_data_1_ID;
            d2_d    = read_data_2_ID;
            imm_d   = imm_ID;
            pc_d    = pc_ID;
            ctrl_d  = ctrl_ID;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_EX          = valid_q;
   assign read_reg_idx_1_EX = rs1_q;
   assign read_reg_idx_2_EX = rs2_q;
   assign write_reg_idx_EX  = rd_q;
   assign read_data_1_EX    = d1_q;
   assign read_data_2_EX    = d2_q;
   assign imm_EX            = imm_q;
   assign pc_EX             = pc_q;
   assign ctrl_EX           = ctrl_q;
   assign load_use_bubbles  = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: a reference model pushes the expected
// EX state per cycle into a queue, popped and compared after each clock edge.
module tb_id_ex_hazard_reg;
   import id_ex_hazard_reg_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 12;
   localparam int NW = 16;

   localparam logic [CW-1:0] C_LW  = (12'd1 << WB_WRITE) | (12'd1 << WB_MEM2REG) | (12'd1 << MEM_READ) | (12'd1 << ALU_SRC);
   localparam logic [CW-1:0] C_ALU = (12'd1 << WB_WRITE) | (12'd3 << ALU_OP_LSB);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_ID = 1'b0, uses_rs1_ID = 1'b0, uses_rs2_ID = 1'b0;
   logic [RW-1:0] read_reg_idx_1_ID = '0, read_reg_idx_2_ID = '0, write_reg_idx_ID = '0;
   logic [DW-1:0] read_data_1_ID = '0, read_data_2_ID = '0, imm_ID = '0, pc_ID = '0;
   logic [CW-1:0] ctrl_ID = '0;
   logic          flush_EX = 1'b0, stall_MEM = 1'b0;
   logic          valid_EX, stall_ID;
   logic [RW-1:0] read_reg_idx_1_EX, read_reg_idx_2_EX, write_reg_idx_EX;
   logic [DW-1:0] read_data_1_EX, read_data_2_EX, imm_EX, pc_EX;
   logic [CW-1:0] ctrl_EX;
   logic [NW-1:0] load_use_bubbles;

   id_ex_hazard_reg #(
      .DATA_W(DW), .REG_IDX_W(RW), .CTRL_W(CW), .CNT_W(NW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
      .read_reg_idx_1_ID(read_reg_idx_1_ID), .read_reg_idx_2_ID(read_reg_idx_2_ID),
      .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
      .read_data_1_ID(read_data_1_ID), .read_data_2_ID(read_data_2_ID),
      .imm_ID(imm_ID), .pc_ID(pc_ID), .write_reg_idx_ID(write_reg_idx_ID), .ctrl_ID(ctrl_ID),
      .flush_EX(flush_EX), .stall_MEM(stall_MEM), .valid_EX(valid_EX),
      .read_reg_idx_1_EX(read_reg_idx_1_EX), .read_reg_idx_2_EX(read_reg_idx_2_EX),
      .read_data_1_EX(read_data_1_EX), .read_data_2_EX(read_data_2_EX),
      .imm_EX(imm_EX), .pc_EX(pc_EX), .write_reg_idx_EX(write_reg_idx_EX), .ctrl_EX(ctrl_EX),
      .stall_ID(stall_ID), .load_use_bubbles(load_use_bubbles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [RW-1:0] rs1, rs2, rd;
      logic [DW-1:0] d1, d2, imm, pc;
      logic [CW-1:0] ctrl;
      logic [NW-1:0] cnt;
   } ex_t;

   ex_t m;
   ex_t q[$];
   int  vectors = 0;
   int  miscompares = 0;

   function automatic ex_t observed();
      return {valid_EX, read_reg_idx_1_EX, read_reg_idx_2_EX, write_reg_idx_EX,
              read_data_1_EX, read_data_2_EX, imm_EX, pc_EX, ctrl_EX, load_use_bubbles};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic [CW-1:0] ctrl);
      valid_ID          = v;
      read_reg_idx_1_ID = rs1;
      read_reg_idx_2_ID = rs2;
      uses_rs1_ID       = u1;
      uses_rs2_ID       = u2;
      write_reg_idx_ID  = rd;
      ctrl_ID           = ctrl;
      read_data_1_ID    = $urandom;
      read_data_2_ID    = $urandom;
      imm_ID            = $urandom;
      pc_ID             = $urandom;
   endtask

   // One clock: check stall_ID against the model, push the expected EX state, clock, compare.
   task automatic cyc(input string tag);
      logic lu;
      ex_t  nx;
      #1;
      lu = m.v && m.ctrl[WB_MEM2REG] && m.ctrl[WB_WRITE] && (m.rd != 0) && valid_ID &&
           ((uses_rs1_ID && read_reg_idx_1_ID == m.rd) || (uses_rs2_ID && read_reg_idx_2_ID == m.rd));
      chk({tag, ":stall_ID"}, 256'(stall_ID), 256'(stall_MEM | (lu & ~flush_EX)));
      if (stall_MEM) nx = m;
      else if (flush_EX) begin nx = '0; nx.cnt = m.cnt; end
      else if (lu) begin nx = '0; nx.cnt = (m.cnt == '1) ? m.cnt : m.cnt + 1'b1; end
      else begin
         nx.v = valid_ID; nx.rs1 = read_reg_idx_1_ID; nx.rs2 = read_reg_idx_2_ID;
         nx.rd = write_reg_idx_ID; nx.d1 = read_data_1_ID; nx.d2 = read_data_2_ID;
         nx.imm = imm_ID; nx.pc = pc_ID; nx.ctrl = ctrl_ID; nx.cnt = m.cnt;
      end
      q.push_back(nx);
      m = nx;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         vectors++; miscompares++;
         $error("FAIL %s:queue observed=empty expected=entry", tag);
      end else chk({tag, ":ex"}, 256'(observed()), 256'(q.pop_front()));
   endtask

   initial begin
      m = '0;
      #2;
      chk("reset_state", 256'(observed()), 256'(0));
      chk("reset_stall", 256'(stall_ID), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // lw x5 then add x6,x5,x7
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, C_LW);  cyc("t2_lw");
      drive(1, 5'd5, 5'd7, 1, 1, 5'd6, C_ALU);
      #1; chk("t2_stall_now", 256'(stall_ID), 256'(1));
      cyc("t2_bubble");
      chk("t2_valid", 256'(valid_EX), 256'(0));
      chk("t2_cnt", 256'(load_use_bubbles), 256'(1));
      cyc("t2_add");
      chk("t2_rs1", 256'(read_reg_idx_1_EX), 256'(5));

      // lw x0 then add reading x0
      drive(1, 5'd2, 5'd0, 1, 0, 5'd0, C_LW);  cyc("t3_lw0");
      drive(1, 5'd0, 5'd0, 1, 1, 5'd8, C_ALU); cyc("t3_add");
      chk("t3_cnt", 256'(load_use_bubbles), 256'(1));

      // ALU producer then consumer: no stall
      drive(1, 5'd3, 5'd4, 1, 1, 5'd5, C_ALU); cyc("t4_add");
      drive(1, 5'd9, 5'd5, 1, 1, 5'd10, C_ALU); cyc("t4_sub");

      // rs2-only consumer of a load
      drive(1, 5'd1, 5'd0, 1, 0, 5'd12, C_LW); cyc("t7_lw");
      drive(1, 5'd0, 5'd12, 0, 1, 5'd13, C_ALU); cyc("t7_bubble");
      cyc("t7_capture");

      // load-use with same-cycle flush
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, C_LW); cyc("t5_lw");
      drive(1, 5'd5, 5'd0, 1, 0, 5'd6, C_ALU); flush_EX = 1'b1;
      cyc("t5_flush");
      chk("t5_cnt", 256'(load_use_bubbles), 256'(2));
      flush_EX = 1'b0;
      drive(1, 5'd11, 5'd0, 1, 0, 5'd14, C_ALU); cyc("t5_next");

      // load-use with 3-cycle memory stall
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, C_LW); cyc("t6_lw");
      drive(1, 5'd5, 5'd7, 1, 1, 5'd6, C_ALU); stall_MEM = 1'b1;
      for (int i = 0; i < 3; i++) cyc("t6_hold");
      chk("t6_frozen_rd", 256'(write_reg_idx_EX), 256'(5));
      stall_MEM = 1'b0;
      cyc("t6_bubble");
      chk("t6_cnt", 256'(load_use_bubbles), 256'(3));
      cyc("t6_add");

      // reset mid-operation with a load in EX, then release
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, C_LW); cyc("t1_lw");
      chk("t1_valid_before", 256'(valid_EX), 256'(1));
      #2; rst_n = 1'b0; #1;
      chk("t1_async_reset", 256'(observed()), 256'(0));
      m = '0;
      @(negedge clk); rst_n = 1'b1;
      drive(1, 5'd5, 5'd0, 1, 0, 5'd6, C_ALU);
      cyc("t1_after_release");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
